// File: rtl/ref_dc_fifo_wc.sv
// Dual-clock N:1 down-sizing FIFO with first-word-fall-through read and Gray-coded pointer sync.
// Define REF_DC_FIFO_WC_ERR_EN to build the sticky wr_ovf/rd_udf error flags; otherwise both are tied low.
module ref_dc_fifo_wc #(
  parameter int ADDR_WIDTH    = 7,
  parameter int RD_DATA_WIDTH = 32,
  parameter int RATIO_LOG2    = 1,
  parameter int AFULL_THRESH  = 120,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                                     rst_n,
  input  logic                                     rd_clk,
  input  logic                                     wr_clk,
  input  logic                                     wr_en,
  input  logic [(RD_DATA_WIDTH<<RATIO_LOG2)-1:0]   wr_data,
  output logic [ADDR_WIDTH:0]                      wr_level,
  output logic                                     wr_full,
  output logic                                     wr_afull,
  output logic                                     wr_ovf,
  input  logic                                     rd_flush,
  input  logic                                     rd_ack,
  output logic [RD_DATA_WIDTH-1:0]                 rd_data,
  output logic                                     rd_valid,
  output logic [ADDR_WIDTH+RATIO_LOG2:0]           rd_level,
  output logic                                     rd_aempty,
  output logic                                     rd_udf
);

  localparam int WW    = RD_DATA_WIDTH << RATIO_LOG2;
  localparam int PW    = ADDR_WIDTH + 1;
  localparam int LVW   = ADDR_WIDTH + RATIO_LOG2 + 1;
  localparam int LW    = (RATIO_LOG2 == 0) ? 1 : RATIO_LOG2;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [PW-1:0]  FULL_LVL   = PW'(DEPTH);
  localparam logic [PW-1:0]  AFULL_LVL  = PW'(AFULL_THRESH);
  localparam logic [LVW-1:0] AEMPTY_LVL = LVW'(AEMPTY_THRESH);
  localparam logic [LW-1:0]  LANE_LAST  = LW'((1 << RATIO_LOG2) - 1);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int unsigned i = 1; i < PW; i++) b = b ^ (g >> i);
    return b;
  endfunction

  logic [WW-1:0] mem [DEPTH];

  // ---------------- write domain ----------------
  logic [1:0]    wrst_q;
  logic          wr_rst_n;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, wr_gray_q, rq_s1_q, rq_s2_q, rd_bin_w;
  logic [PW-1:0] wr_level_q, wr_level_d;
  logic          wr_full_q, wr_full_d, wr_afull_q, wr_afull_d, wr_push;
  logic [PW-1:0] rd_gray_q;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) wrst_q <= '0;
    else        wrst_q <= {wrst_q[0], 1'b1};
  end
  assign wr_rst_n = wrst_q[1];

  always_comb begin
    wr_push    = wr_en & ~wr_full_q;
    wr_ptr_d   = wr_ptr_q + PW'(wr_push);
    rd_bin_w   = gray2bin(rq_s2_q);
    wr_level_d = wr_ptr_d - rd_bin_w;
    wr_full_d  = (wr_level_d == FULL_LVL);
    wr_afull_d = (wr_level_d >= AFULL_LVL);
  end

  always_ff @(posedge wr_clk) begin
    if (wr_push) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= wr_data;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_ptr_q   <= '0;
      wr_gray_q  <= '0;
      rq_s1_q    <= '0;
      rq_s2_q    <= '0;
      wr_level_q <= '0;
      wr_full_q  <= 1'b0;
      wr_afull_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      wr_gray_q  <= bin2gray(wr_ptr_d);
      rq_s1_q    <= rd_gray_q;
      rq_s2_q    <= rq_s1_q;
      wr_level_q <= wr_level_d;
      wr_full_q  <= wr_full_d;
      wr_afull_q <= wr_afull_d;
    end
  end

  assign wr_level = wr_level_q;
  assign wr_full  = wr_full_q;
  assign wr_afull = wr_afull_q;

  // ---------------- read domain ----------------
  logic [1:0]     rrst_q;
  logic           rd_rst_n;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wq_s1_q, wq_s2_q, wr_bin_r, entries;
  logic [LW-1:0]  lane_q, lane_d;
  logic           rd_valid_q, rd_valid_d, rd_aempty_q, rd_aempty_d;
  logic           ack_ok, lane_last, pop;
  logic [WW-1:0]  rd_word_q, rd_word_d;
  logic [LVW-1:0] rd_level_q, rd_level_d;

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) rrst_q <= '0;
    else        rrst_q <= {rrst_q[0], 1'b1};
  end
  assign rd_rst_n = rrst_q[1];

  // Output register is refilled from the post-pop pointer in the same cycle, so a pop on the
  // last lane presents the next write word immediately with no bubble.
  always_comb begin
    wr_bin_r   = gray2bin(wq_s2_q);
    ack_ok     = rd_ack & rd_valid_q;
    lane_last  = (lane_q == LANE_LAST);
    pop        = ack_ok & lane_last;
    rd_ptr_d   = rd_ptr_q + PW'(pop);
    lane_d     = ack_ok ? (lane_last ? '0 : lane_q + LW'(1)) : lane_q;
    entries    = wr_bin_r - rd_ptr_d;
    rd_valid_d = rd_valid_q;
    rd_word_d  = rd_word_q;
    if (!rd_valid_q || pop) begin
      rd_valid_d = (entries != '0);
      rd_word_d  = (entries != '0) ? mem[rd_ptr_d[ADDR_WIDTH-1:0]] : '0;
    end
    if (rd_flush) begin
      rd_ptr_d   = wr_bin_r;
      lane_d     = '0;
      entries    = '0;
      rd_valid_d = 1'b0;
      rd_word_d  = '0;
    end
    rd_level_d  = (LVW'(entries) << RATIO_LOG2) - LVW'(lane_d);
    rd_aempty_d = (rd_level_d <= AEMPTY_LVL);
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_ptr_q    <= '0;
      rd_gray_q   <= '0;
      wq_s1_q     <= '0;
      wq_s2_q     <= '0;
      rd_valid_q  <= 1'b0;
      rd_word_q   <= '0;
      rd_level_q  <= '0;
      rd_aempty_q <= 1'b1;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      rd_gray_q   <= bin2gray(rd_ptr_d);
      wq_s1_q     <= wr_gray_q;
      wq_s2_q     <= wq_s1_q;
      rd_valid_q  <= rd_valid_d;
      rd_word_q   <= rd_word_d;
      rd_level_q  <= rd_level_d;
      rd_aempty_q <= rd_aempty_d;
    end
  end

  generate
    if (RATIO_LOG2 > 0) begin : g_lane
      always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) lane_q <= '0;
        else           lane_q <= lane_d;
      end
    end else begin : g_no_lane
      assign lane_q = '0;
    end
  endgenerate

  assign rd_data   = rd_word_q[lane_q*RD_DATA_WIDTH +: RD_DATA_WIDTH];
  assign rd_valid  = rd_valid_q;
  assign rd_level  = rd_level_q;
  assign rd_aempty = rd_aempty_q;

`ifdef REF_DC_FIFO_WC_ERR_EN
  logic wr_ovf_q, rd_udf_q;

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n)                wr_ovf_q <= 1'b0;
    else if (wr_en && wr_full_q)  wr_ovf_q <= 1'b1;
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n)                rd_udf_q <= 1'b0;
    else if (rd_ack && !rd_valid_q) rd_udf_q <= 1'b1;
  end

  assign wr_ovf = wr_ovf_q;
  assign rd_udf = rd_udf_q;
`else
  assign wr_ovf = 1'b0;
  assign rd_udf = 1'b0;
`endif

endmodule

// File: tb/tb_ref_dc_fifo_wc.sv
// Directed bench for ref_dc_fifo_wc: lane-order scoreboard, full/almost flags, flush, underflow, async reset.
`timescale 1ns/1ps
module tb_ref_dc_fifo_wc;

  localparam int AW    = 7;
  localparam int RDW   = 32;
  localparam int RL2   = 1;
  localparam int RATIO = 1 << RL2;
  localparam int WW    = RDW << RL2;
`ifdef REF_DC_FIFO_WC_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic              rst_n, rd_clk, wr_clk, wr_en, rd_flush, rd_ack;
  logic [WW-1:0]     wr_data;
  logic [AW:0]       wr_level;
  logic              wr_full, wr_afull, wr_ovf;
  logic [RDW-1:0]    rd_data;
  logic              rd_valid, rd_aempty, rd_udf;
  logic [AW+RL2:0]   rd_level;

  int wr_half = 5;
  int rd_half = 5;
  int checks  = 0;
  int errors  = 0;
  logic [RDW-1:0] exp_q[$];

  initial wr_clk = 1'b0;
  always #(wr_half) wr_clk = ~wr_clk;
  initial rd_clk = 1'b0;
  always #(rd_half) rd_clk = ~rd_clk;

  ref_dc_fifo_wc #(
    .ADDR_WIDTH(AW), .RD_DATA_WIDTH(RDW), .RATIO_LOG2(RL2),
    .AFULL_THRESH(120), .AEMPTY_THRESH(2)
  ) dut (
    .rst_n(rst_n), .rd_clk(rd_clk), .wr_clk(wr_clk),
    .wr_en(wr_en), .wr_data(wr_data), .wr_level(wr_level), .wr_full(wr_full),
    .wr_afull(wr_afull), .wr_ovf(wr_ovf),
    .rd_flush(rd_flush), .rd_ack(rd_ack), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_level(rd_level), .rd_aempty(rd_aempty), .rd_udf(rd_udf)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic sb_push(input logic [WW-1:0] w);
    for (int unsigned k = 0; k < RATIO; k++) exp_q.push_back(w[k*RDW +: RDW]);
  endtask

  task automatic sb_check(input string tag);
    checks++;
    assert (exp_q.size() != 0) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, rd_data);
    end
    if (exp_q.size() != 0) check(tag, rd_data, exp_q.pop_front());
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_level"}, wr_level, 0);
    check({tag, "_wr_full"}, wr_full, 0);
    check({tag, "_wr_afull"}, wr_afull, 0);
    check({tag, "_wr_ovf"}, wr_ovf, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_rd_data"}, rd_data, 0);
    check({tag, "_rd_level"}, rd_level, 0);
    check({tag, "_rd_aempty"}, rd_aempty, 1);
    check({tag, "_rd_udf"}, rd_udf, 0);
  endtask

  task automatic wr_push(input logic [WW-1:0] w);
    @(negedge wr_clk);
    wr_en   = 1'b1;
    wr_data = w;
    sb_push(w);
  endtask

  task automatic wr_idle();
    @(negedge wr_clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_pop(input string tag);
    @(negedge rd_clk);
    check({tag, "_valid"}, rd_valid, 1);
    sb_check(tag);
    rd_ack = 1'b1;
  endtask

  task automatic rd_idle();
    @(negedge rd_clk);
    rd_ack = 1'b0;
  endtask

  task automatic wait_rd_valid(input string tag, input int limit);
    int n = 0;
    while (!rd_valid && n < limit) begin
      @(negedge rd_clk);
      n++;
    end
    check(tag, rd_valid, 1);
  endtask

  task automatic run_stream(input string tag, input int nw);
    int sent = 0;
    int got  = 0;
    fork
      begin
        int g = 0;
        while (sent < nw && g < 40000) begin
          @(negedge wr_clk);
          g++;
          if (!wr_full && $urandom_range(0, 3) != 0) begin
            wr_en   = 1'b1;
            wr_data = {$urandom(), $urandom()};
            sb_push(wr_data);
            sent++;
          end else begin
            wr_en = 1'b0;
          end
        end
        @(negedge wr_clk);
        wr_en = 1'b0;
      end
      begin
        int g = 0;
        while (got < nw * RATIO && g < 40000) begin
          @(negedge rd_clk);
          g++;
          if (rd_valid && $urandom_range(0, 3) != 0) begin
            sb_check({tag, "_data"});
            rd_ack = 1'b1;
            got++;
          end else begin
            rd_ack = 1'b0;
          end
        end
        @(negedge rd_clk);
        rd_ack = 1'b0;
      end
    join
    check({tag, "_sent"}, sent, nw);
    check({tag, "_got"}, got, nw * RATIO);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
    check({tag, "_ovf"}, wr_ovf, ERR_EN);
    check({tag, "_udf"}, rd_udf, 0);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; rd_ack = 1'b0; rd_flush = 1'b0;
    repeat (3) @(negedge rd_clk);
    check_reset("rst");
    rst_n = 1'b1;
    repeat (6) @(negedge rd_clk);
    check_reset("rst_rel");

    // 1: one write word unpacks lane 0 then lane 1
    wr_push(64'hBBBBBBBB_AAAAAAAA);
    wr_idle();
    wait_rd_valid("t1_valid", 20);
    check("t1_rd_level", rd_level, 2);
    check("t1_aempty", rd_aempty, 1);
    rd_pop("t1_lane0");
    rd_pop("t1_lane1");
    rd_idle();
    check("t1_valid_drop", rd_valid, 0);
    check("t1_data_zero", rd_data, 0);
    check("t1_level_zero", rd_level, 0);

    // 2: fill to full with reader idle, overflow attempt, full drain
    repeat (10) @(negedge wr_clk);
    for (int i = 0; i <= 128; i++) begin
      @(negedge wr_clk);
      check("t2_wr_level", wr_level, i);
      check("t2_wr_afull", wr_afull, (i >= 120));
      check("t2_wr_full", wr_full, (i == 128));
      wr_en   = 1'b1;
      wr_data = {16'hC0DE, 16'(2*i+1), 16'hC0DE, 16'(2*i)};
      if (i < 128) sb_push(wr_data);
    end
    @(negedge wr_clk);
    wr_en = 1'b0;
    check("t2_level_after_drop", wr_level, 128);
    check("t2_full_after_drop", wr_full, 1);
    check("t2_ovf", wr_ovf, ERR_EN);
    repeat (10) @(negedge rd_clk);
    for (int k = 0; k < 256; k++) begin
      @(negedge rd_clk);
      check("t2_rd_level", rd_level, 256 - k);
      check("t2_rd_aempty", rd_aempty, ((256 - k) <= 2));
      check("t2_no_bubble", rd_valid, 1);
      sb_check("t2_drain");
      rd_ack = 1'b1;
    end
    rd_idle();
    check("t2_valid_end", rd_valid, 0);
    check("t2_level_end", rd_level, 0);
    check("t2_aempty_end", rd_aempty, 1);
    repeat (10) @(negedge wr_clk);
    check("t2_wr_level_end", wr_level, 0);
    check("t2_wr_full_end", wr_full, 0);

    // 3: continuous traffic, both clock ratios, many pointer wraps
    wr_half = 2; rd_half = 5;
    repeat (4) @(negedge rd_clk);
    run_stream("t3_wfast", 2500);
    wr_half = 5; rd_half = 2;
    repeat (4) @(negedge wr_clk);
    run_stream("t3_rfast", 2500);
    wr_half = 5; rd_half = 5;
    repeat (10) @(negedge rd_clk);

    // 4: flush together with ack after one lane consumed
    for (int i = 0; i < 4; i++) wr_push({32'h4400_0000 + 32'(2*i+1), 32'h4400_0000 + 32'(2*i)});
    wr_idle();
    repeat (12) @(negedge rd_clk);
    check("t4_level_loaded", rd_level, 8);
    rd_pop("t4_first");
    @(negedge rd_clk);
    rd_flush = 1'b1;
    rd_ack   = 1'b1;
    @(negedge rd_clk);
    rd_flush = 1'b0;
    rd_ack   = 1'b0;
    check("t4_valid_flushed", rd_valid, 0);
    check("t4_level_flushed", rd_level, 0);
    check("t4_data_flushed", rd_data, 0);
    exp_q.delete();
    repeat (10) @(negedge rd_clk);
    check("t4_stays_empty", rd_valid, 0);
    check("t4_wr_level_freed", wr_level, 0);
    wr_push(64'h5555_0002_5555_0001);
    wr_idle();
    wait_rd_valid("t4_new_valid", 20);
    rd_pop("t4_new_lane0");
    rd_pop("t4_new_lane1");
    rd_idle();
    check("t4_new_drained", rd_valid, 0);

    // 5: ack while empty
    repeat (6) @(negedge rd_clk);
    rd_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge rd_clk);
      check("t5_data", rd_data, 0);
      check("t5_valid", rd_valid, 0);
      check("t5_level", rd_level, 0);
    end
    rd_ack = 1'b0;
    repeat (4) @(negedge rd_clk);
    check("t5_udf_sticky", rd_udf, ERR_EN);
    wr_push(64'h6666_0002_6666_0001);
    wr_idle();
    wait_rd_valid("t5_after_valid", 20);
    rd_pop("t5_after_lane0");
    rd_pop("t5_after_lane1");
    rd_idle();

    // 6: async reset with 50 entries held
    for (int i = 0; i < 50; i++) wr_push({32'h7700_0000 + 32'(2*i+1), 32'h7700_0000 + 32'(2*i)});
    wr_idle();
    repeat (10) @(negedge rd_clk);
    check("t6_wr_level", wr_level, 50);
    check("t6_rd_level", rd_level, 100);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("t6_async");
    exp_q.delete();
    repeat (3) @(negedge rd_clk);
    rst_n = 1'b1;
    repeat (6) @(negedge rd_clk);
    check_reset("t6_post");
    wr_push(64'h8888_0002_8888_0001);
    wr_idle();
    wait_rd_valid("t6_new_valid", 20);
    rd_pop("t6_new_lane0");
    rd_pop("t6_new_lane1");
    rd_idle();
    check("t6_new_drained", rd_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
